// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage and the data memory.
// Valid/ready: req held stable until ready is seen.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: loads/stores over a valid/ready bus.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned accesses.
module mem_stage #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_err,
    output logic        misalign_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int TO_W =
        (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(BUS_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      alo_q, alo_d;
    logic            rw_q, rw_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            wbv_d, wbrw_d;
    logic [4:0]      wbrd_d;
    logic [31:0]     wbdata_d;
    logic            berr_d, merr_d;

    logic [3:0]      be_new;
    logic [31:0]     wdata_new;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_val;
    logic            mem_op;
    logic            trap;

    assign stall      = (state_q == BUSY);
    assign dmem.req   = (state_q == BUSY);
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.be    = be_q;

    assign mem_op = ex_mem_read | ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap =
        (ex_funct3[1:0] == 2'b01 && ex_alu_result[0]) ||
        (ex_funct3[1] && ex_alu_result[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // Byte-lane mask and replicated store data from access width
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = ex_rs2;
        unique case (ex_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << ex_alu_result[1:0];
                wdata_new = {4{ex_rs2[7:0]}};
            end
            2'b01: begin
                be_new    = ex_alu_result[1] ? 4'b1100
                                             : 4'b0011;
                wdata_new = {2{ex_rs2[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = ex_rs2;
            end
        endcase
    end

    // Lane select and sign/zero extension of returned load data
    always_comb begin
        ld_byte = dmem.rdata[{alo_q, 3'b000} +: 8];
        ld_half = alo_q[1] ? dmem.rdata[31:16]
                           : dmem.rdata[15:0];
        ld_val  = dmem.rdata;
        unique case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'b0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'b0, ld_half};
            default: ld_val = dmem.rdata;
        endcase
    end

    // Next-state and next write-back bundle
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        f3_d     = f3_q;
        alo_d    = alo_q;
        rw_d     = rw_q;
        cnt_d    = cnt_q;
        wbv_d    = 1'b0;
        wbrw_d   = wb_reg_write;
        wbrd_d   = wb_rd;
        wbdata_d = wb_data;
        berr_d   = 1'b0;
        merr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_valid && !mem_op) begin
                    wbv_d    = 1'b1;
                    wbrw_d   = ex_reg_write;
                    wbrd_d   = ex_rd;
                    wbdata_d = ex_alu_result;
                end else if (ex_valid && trap) begin
                    wbv_d    = 1'b1;
                    wbrw_d   = 1'b0;
                    wbrd_d   = ex_rd;
                    merr_d   = 1'b1;
                end else if (ex_valid) begin
                    state_d = BUSY;
                    addr_d  = {ex_alu_result[31:2], 2'b00};
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    we_d    = ex_mem_write;
                    f3_d    = ex_funct3;
                    alo_d   = ex_alu_result[1:0];
                    rw_d    = ex_reg_write;
                    wbrd_d  = ex_rd;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (dmem.ready) begin
                    state_d = IDLE;
                    wbv_d   = 1'b1;
                    if (we_q) begin
                        wbrw_d = 1'b0;
                    end else begin
                        wbrw_d   = rw_q;
                        wbdata_d = ld_val;
                    end
                end else if (BUS_TIMEOUT != 0 &&
                             cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    wbv_d   = 1'b1;
                    wbrw_d  = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and write-back registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            alo_q        <= '0;
            rw_q         <= 1'b0;
            cnt_q        <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            alo_q        <= alo_d;
            rw_q         <= rw_d;
            cnt_q        <= cnt_d;
            wb_valid     <= wbv_d;
            wb_reg_write <= wbrw_d;
            wb_rd        <= wbrd_d;
            wb_data      <= wbdata_d;
            bus_err      <= berr_d;
            misalign_err <= merr_d;
        end
    end

endmodule
